flash_arbiter: RTL and testbench
================================

FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter ADDR_W, 24, flash address width.
REQ-002 Parameter DATA_W, 8, flash data width.
REQ-003 Parameter TO_CYC, 1000, flash watchdog limit in clock cycles, range 2..65535.
REQ-004 CLK_50MHZ  in  1  sole clock; all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 M_REQ  in  1  manager (serial command path) request, level, held until M_DONE.
REQ-007 M_WE  in  1  manager op: 1 = write, 0 = read; sampled with M_REQ.
REQ-008 M_ADDR  in  ADDR_W  manager address; M_WDATA  in  DATA_W  manager write data.
REQ-009 M_GNT  out  1  manager owns flash; M_DONE  out  1  one-cycle completion pulse.
REQ-010 M_RDATA  out  DATA_W  manager read result; M_ERR  out  1  set with M_DONE on timeout.
REQ-011 D_REQ  in  1  display-refresh read request, level; D_ADDR  in  ADDR_W  display address.
REQ-012 D_GNT, D_DONE, D_ERR  out  1 each; D_RDATA  out  DATA_W; same meaning as manager side.
REQ-013 FL_START  out  1  one-cycle pulse starting a flash-controller operation.
REQ-014 FL_WE  out  1; FL_ADDR  out  ADDR_W; FL_WDATA  out  DATA_W; held stable from FL_START until completion.
REQ-015 FL_RDATA  in  DATA_W  valid in the cycle FL_STATUS = 1.
REQ-016 FL_STATUS  in  1  one-cycle completion pulse from the flash controller.

Function
REQ-017 States: IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-018 IDLE: no request -> stay; one request -> latch its op/addr/wdata, go ISSUE.
REQ-019 Both requests in the same IDLE cycle -> grant the requester that did not win last; last_win resets to display, so the manager wins the first tie.
REQ-020 Display requests are always reads: FL_WE = 0, FL_WDATA = 0.
REQ-021 ISSUE: FL_START = 1 for exactly this cycle, winner GNT = 1; next state WAIT, watchdog cleared.
REQ-022 Latency: request sampled in IDLE at edge n -> FL_START and GNT high in cycle n+1.
REQ-023 WAIT: watchdog increments each cycle; FL_STATUS = 1 -> capture FL_RDATA into winner RDATA (reads only), go DONE.
REQ-024 WAIT: watchdog reaches TO_CYC without FL_STATUS -> go DONE with winner ERR = 1, RDATA unchanged.
REQ-025 FL_STATUS and timeout in the same cycle -> FL_STATUS wins, ERR = 0.
REQ-026 DONE: winner DONE = 1 for one cycle, GNT still 1; ERR valid this cycle only; next state IDLE, GNT low.
REQ-027 Requester still asserting REQ in IDLE after its DONE is a new request; the round-robin rule applies.
REQ-028 Loser's request pending while the other is served -> held, arbitrated on return to IDLE; never dropped.
REQ-029 Request inputs and address/data changing after latching have no effect on FL_* outputs.
REQ-030 FL_STATUS outside WAIT is ignored.
REQ-031 At most one GNT high in any cycle; GNT high only in ISSUE, WAIT, DONE.

Reset
REQ-032 RST = 1 at a clock edge -> state IDLE, watchdog 0, last_win = display, all outputs 0, including *_RDATA.
REQ-033 RST during WAIT abandons the operation: no DONE pulse, FL_START does not re-pulse; FL_STATUS arriving after reset is ignored.

Structure
REQ-034 Shared package holds state encoding localparams, ADDR_W/DATA_W defaults and requester-ID constants (REQ_MGR = 0, REQ_DSP = 1).
REQ-035 Watchdog is one sub-module, fl_watchdog (clear, enable, terminal-count output, parameter TO_CYC); arbitration and FSM remain in flash_arbiter.

Verification
REQ-036 M_REQ write addr 0x000010 data 0xA5, FL_STATUS 3 cycles after FL_START -> FL_WE = 1, FL_ADDR = 0x000010, FL_WDATA = 0xA5, M_DONE pulse, M_ERR = 0.
REQ-037 D_REQ addr 0x000020, FL_RDATA = 0x3C with FL_STATUS -> D_RDATA = 0x3C on D_DONE, FL_WE = 0.
REQ-038 M_REQ and D_REQ rise together and stay high for 4 operations -> order manager, display, manager, display.
REQ-039 TO_CYC = 8, no FL_STATUS -> M_DONE with M_ERR = 1 exactly 8 cycles after entering WAIT, then IDLE.
REQ-040 RST pulsed 2 cycles after FL_START -> all outputs 0, no DONE; late FL_STATUS ignored; next request served normally.
REQ-041 FL_STATUS injected in IDLE, and on the timeout cycle -> ignored in IDLE; on the timeout cycle ERR = 0 and read data captured.

Source files
------------

// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the flash arbiter: state encoding, default widths,
// requester IDs and the round-robin pick helper.
package flash_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 24;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StIssue = ST_ISSUE,
        StWait  = ST_WAIT,
        StDone  = ST_DONE
    } arb_state_e;

    localparam logic REQ_MGR = 1'b0;
    localparam logic REQ_DSP = 1'b1;

    // On a tie the requester that did not win last time is served.
    function automatic logic rr_pick(input logic m_req, input logic d_req, input logic last_win);
        logic pick;
        if (m_req && d_req) begin
            pick = (last_win == REQ_MGR) ? REQ_DSP : REQ_MGR;
        end else if (m_req) begin
            pick = REQ_MGR;
        end else begin
            pick = REQ_DSP;
        end
        return pick;
    endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Bundle of requester (manager, display) and flash-controller signals seen by the arbiter.
// The arbiter uses the slave view; the surrounding system drives the master view.
interface flash_arbiter_if
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              M_REQ;
    logic              M_WE;
    logic [ADDR_W-1:0] M_ADDR;
    logic [DATA_W-1:0] M_WDATA;
    logic              M_GNT;
    logic              M_DONE;
    logic [DATA_W-1:0] M_RDATA;
    logic              M_ERR;

    logic              D_REQ;
    logic [ADDR_W-1:0] D_ADDR;
    logic              D_GNT;
    logic              D_DONE;
    logic [DATA_W-1:0] D_RDATA;
    logic              D_ERR;

    logic              FL_START;
    logic              FL_WE;
    logic [ADDR_W-1:0] FL_ADDR;
    logic [DATA_W-1:0] FL_WDATA;
    logic [DATA_W-1:0] FL_RDATA;
    logic              FL_STATUS;

    modport slave (
        input  M_REQ, M_WE, M_ADDR, M_WDATA,
        output M_GNT, M_DONE, M_RDATA, M_ERR,
        input  D_REQ, D_ADDR,
        output D_GNT, D_DONE, D_RDATA, D_ERR,
        output FL_START, FL_WE, FL_ADDR, FL_WDATA,
        input  FL_RDATA, FL_STATUS
    );

    modport master (
        output M_REQ, M_WE, M_ADDR, M_WDATA,
        input  M_GNT, M_DONE, M_RDATA, M_ERR,
        output D_REQ, D_ADDR,
        input  D_GNT, D_DONE, D_RDATA, D_ERR,
        input  FL_START, FL_WE, FL_ADDR, FL_WDATA,
        output FL_RDATA, FL_STATUS
    );

endinterface

// File: rtl/flash_arbiter_fl_watchdog.sv
// Flash operation watchdog: counts enabled cycles and flags the TO_CYC-th one.
// Count saturates at the terminal value so a stalled FSM never wraps it.
module fl_watchdog #(
    parameter int unsigned TO_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [15:0] LastCnt = 16'(TO_CYC - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LastCnt)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tc = enable && (cnt_q == LastCnt);

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one flash controller between the manager (read/write)
// and the display refresher (read-only), with a per-operation watchdog.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TO_CYC = 1000
) (
    input logic            CLK_50MHZ,
    input logic            RST,
    flash_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;
    logic last_win_q, last_win_d;
    logic owner_q, owner_d;
    logic pick;

    logic              fl_start_q, fl_start_d;
    logic              fl_we_q, fl_we_d;
    logic [ADDR_W-1:0] fl_addr_q, fl_addr_d;
    logic [DATA_W-1:0] fl_wdata_q, fl_wdata_d;

    logic              m_gnt_q, m_gnt_d;
    logic              m_done_q, m_done_d;
    logic              m_err_q, m_err_d;
    logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

    logic              d_gnt_q, d_gnt_d;
    logic              d_done_q, d_done_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic wd_clear, wd_enable, wd_tc;

    assign wd_enable = (state_q == StWait);
    assign wd_clear  = (state_q != StWait);

    fl_watchdog #(
        .TO_CYC (TO_CYC)
    ) u_watchdog (
        .clk    (CLK_50MHZ),
        .rst    (RST),
        .clear  (wd_clear),
        .enable (wd_enable),
        .tc     (wd_tc)
    );

    // Every output is a register loaded from its next-state value.
    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        owner_d    = owner_q;
        fl_start_d = 1'b0;
        fl_we_d    = fl_we_q;
        fl_addr_d  = fl_addr_q;
        fl_wdata_d = fl_wdata_q;
        m_gnt_d    = m_gnt_q;
        m_done_d   = 1'b0;
        m_err_d    = 1'b0;
        m_rdata_d  = m_rdata_q;
        d_gnt_d    = d_gnt_q;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        pick       = rr_pick(bus.M_REQ, bus.D_REQ, last_win_q);

        unique case (state_q)
            StIdle: begin
                if (bus.M_REQ || bus.D_REQ) begin
                    state_d    = StIssue;
                    owner_d    = pick;
                    last_win_d = pick;
                    fl_start_d = 1'b1;
                    if (pick == REQ_MGR) begin
                        fl_we_d    = bus.M_WE;
                        fl_addr_d  = bus.M_ADDR;
                        fl_wdata_d = bus.M_WDATA;
                        m_gnt_d    = 1'b1;
                    end else begin
                        fl_we_d    = 1'b0;
                        fl_addr_d  = bus.D_ADDR;
                        fl_wdata_d = '0;
                        d_gnt_d    = 1'b1;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // A completion landing on the timeout cycle takes priority over the error.
                if (bus.FL_STATUS || wd_tc) begin
                    state_d = StDone;
                    if (owner_q == REQ_MGR) begin
                        m_done_d = 1'b1;
                        m_err_d  = !bus.FL_STATUS;
                        if (bus.FL_STATUS && !fl_we_q) begin
                            m_rdata_d = bus.FL_RDATA;
                        end
                    end else begin
                        d_done_d = 1'b1;
                        d_err_d  = !bus.FL_STATUS;
                        if (bus.FL_STATUS) begin
                            d_rdata_d = bus.FL_RDATA;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                m_gnt_d = 1'b0;
                d_gnt_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q    <= StIdle;
            last_win_q <= REQ_DSP;
            owner_q    <= REQ_MGR;
            fl_start_q <= 1'b0;
            fl_we_q    <= 1'b0;
            fl_addr_q  <= '0;
            fl_wdata_q <= '0;
            m_gnt_q    <= 1'b0;
            m_done_q   <= 1'b0;
            m_err_q    <= 1'b0;
            m_rdata_q  <= '0;
            d_gnt_q    <= 1'b0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
            owner_q    <= owner_d;
            fl_start_q <= fl_start_d;
            fl_we_q    <= fl_we_d;
            fl_addr_q  <= fl_addr_d;
            fl_wdata_q <= fl_wdata_d;
            m_gnt_q    <= m_gnt_d;
            m_done_q   <= m_done_d;
            m_err_q    <= m_err_d;
            m_rdata_q  <= m_rdata_d;
            d_gnt_q    <= d_gnt_d;
            d_done_q   <= d_done_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.M_GNT    = m_gnt_q;
    assign bus.M_DONE   = m_done_q;
    assign bus.M_ERR    = m_err_q;
    assign bus.M_RDATA  = m_rdata_q;
    assign bus.D_GNT    = d_gnt_q;
    assign bus.D_DONE   = d_done_q;
    assign bus.D_ERR    = d_err_q;
    assign bus.D_RDATA  = d_rdata_q;
    assign bus.FL_START = fl_start_q;
    assign bus.FL_WE    = fl_we_q;
    assign bus.FL_ADDR  = fl_addr_q;
    assign bus.FL_WDATA = fl_wdata_q;

    gnt_exclusive_a : assert property (@(posedge CLK_50MHZ) disable iff (RST)
        !(m_gnt_q && d_gnt_q));

    gnt_idle_a : assert property (@(posedge CLK_50MHZ) disable iff (RST)
        (state_q == StIdle) |-> !(m_gnt_q || d_gnt_q));

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: vector table plus corner sequences,
// with a scoreboard matching flash starts and requester completions.
module tb_flash_arbiter;

    typedef struct {
        logic        is_mgr;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
        int          delay;     // cycles from FL_START to FL_STATUS, 0 = never answer
        logic [7:0]  fl_rdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from FL_START to DONE
    } vec_t;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } fl_exp_t;

    typedef struct {
        logic       is_mgr;
        logic [7:0] rdata;
        logic       err;
    } done_exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fl_exp_t   fl_q[$];
    done_exp_t exp_q[$];
    fl_exp_t   cur_fl;
    vec_t      vecs[9];
    logic [7:0] tie_rd[4];

    flash_arbiter_if #(.ADDR_W(24), .DATA_W(8)) bus ();

    flash_arbiter #(
        .ADDR_W (24),
        .DATA_W (8),
        .TO_CYC (8)
    ) dut (
        .CLK_50MHZ (clk),
        .RST       (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic push_fl(input logic we, input logic [23:0] addr, input logic [7:0] wdata);
        fl_exp_t f;
        f.we = we;
        f.addr = addr;
        f.wdata = wdata;
        fl_q.push_back(f);
    endtask

    task automatic push_done(input logic is_mgr, input logic [7:0] rdata, input logic err);
        done_exp_t e;
        e.is_mgr = is_mgr;
        e.rdata = rdata;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mgr"}, 32'({bus.M_GNT, bus.M_DONE, bus.M_ERR, bus.M_RDATA}), 32'd0);
        check({tag, "_dsp"}, 32'({bus.D_GNT, bus.D_DONE, bus.D_ERR, bus.D_RDATA}), 32'd0);
        check({tag, "_fl"}, 32'({bus.FL_START, bus.FL_WE, bus.FL_WDATA}), 32'd0);
        check({tag, "_fladdr"}, 32'(bus.FL_ADDR), 32'd0);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.FL_START && n < 20);
    endtask

    task automatic count_events(input int cycles, output int ev);
        ev = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.FL_START || bus.M_DONE || bus.D_DONE) ev++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.M_REQ = 1'b0;
        bus.D_REQ = 1'b0;
        bus.FL_STATUS = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left on a negedge inside an IDLE cycle.
    task automatic run_op(input vec_t v);
        int n;
        push_fl(v.is_mgr ? v.we : 1'b0, v.addr, v.is_mgr ? v.wdata : 8'h00);
        push_done(v.is_mgr, v.exp_rdata, v.exp_err);
        bus.M_REQ   = v.is_mgr;
        bus.M_WE    = v.is_mgr ? v.we : 1'b1;
        bus.M_ADDR  = v.is_mgr ? v.addr : ~v.addr;
        bus.M_WDATA = v.is_mgr ? v.wdata : 8'hFF;
        bus.D_REQ   = !v.is_mgr;
        bus.D_ADDR  = v.is_mgr ? ~v.addr : v.addr;
        wait_start(n);
        check("start_lat", n, 1);
        // Latched values must not follow the inputs any more.
        bus.M_ADDR   = ~bus.M_ADDR;
        bus.M_WDATA  = ~bus.M_WDATA;
        bus.M_WE     = ~bus.M_WE;
        bus.D_ADDR   = ~bus.D_ADDR;
        bus.FL_RDATA = v.fl_rdata;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            bus.FL_STATUS = (v.delay != 0) && (n == v.delay);
            if (bus.M_DONE || bus.D_DONE) break;
        end
        bus.FL_STATUS = 1'b0;
        check("done_lat", n, v.exp_lat);
        bus.M_REQ = 1'b0;
        bus.D_REQ = 1'b0;
        @(negedge clk);
        check("idle_after_done", 32'({bus.M_GNT, bus.D_GNT, bus.M_DONE, bus.D_DONE}), 32'd0);
    endtask

    // Scoreboard: pops flash-start and completion expectations as the DUT produces them.
    always @(negedge clk) begin
        done_exp_t e;
        if (!rst) begin
            check("gnt_excl", 32'(bus.M_GNT & bus.D_GNT), 32'd0);
            check("err_without_done",
                  32'((bus.M_ERR & !bus.M_DONE) | (bus.D_ERR & !bus.D_DONE)), 32'd0);
            if (bus.FL_START) begin
                if (fl_q.size() == 0) begin
                    fail_now("unexpected_fl_start");
                end else begin
                    cur_fl = fl_q.pop_front();
                    check("fl_we", 32'(bus.FL_WE), 32'(cur_fl.we));
                    check("fl_addr", 32'(bus.FL_ADDR), 32'(cur_fl.addr));
                    check("fl_wdata", 32'(bus.FL_WDATA), 32'(cur_fl.wdata));
                end
            end
            if (bus.M_DONE || bus.D_DONE) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("done_who", 32'({bus.M_DONE, bus.D_DONE}),
                          e.is_mgr ? 32'd2 : 32'd1);
                    check("done_gnt", 32'({bus.M_GNT, bus.D_GNT}),
                          e.is_mgr ? 32'd2 : 32'd1);
                    check("done_err", 32'(e.is_mgr ? bus.M_ERR : bus.D_ERR), 32'(e.err));
                    check("done_rdata", 32'(e.is_mgr ? bus.M_RDATA : bus.D_RDATA),
                          32'(e.rdata));
                    check("fl_held", 32'({bus.FL_WE, bus.FL_ADDR}),
                          32'({cur_fl.we, cur_fl.addr}));
                    check("fl_wdata_held", 32'(bus.FL_WDATA), 32'(cur_fl.wdata));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   ev;
        vec_t v;

        n_checks = 0;
        n_pass = 0;
        //          mgr   we    addr          wdata  dly fl_rd  exp_rd err   lat
        vecs[0] = '{1'b1, 1'b1, 24'h000010, 8'hA5, 3, 8'hEE, 8'h00, 1'b0, 4};
        vecs[1] = '{1'b0, 1'b0, 24'h000020, 8'h00, 3, 8'h3C, 8'h3C, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b0, 24'h123456, 8'h9D, 1, 8'h5A, 8'h5A, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 8'h00, 5, 8'hC3, 8'hC3, 1'b0, 6};
        vecs[4] = '{1'b1, 1'b0, 24'h000000, 8'h00, 0, 8'h77, 8'h5A, 1'b1, 9};
        vecs[5] = '{1'b1, 1'b1, 24'hABCDEF, 8'hFF, 2, 8'h66, 8'h5A, 1'b0, 3};
        vecs[6] = '{1'b0, 1'b0, 24'h000100, 8'h00, 0, 8'h55, 8'hC3, 1'b1, 9};
        vecs[7] = '{1'b0, 1'b0, 24'h000200, 8'h00, 8, 8'h81, 8'h81, 1'b0, 9};
        vecs[8] = '{1'b1, 1'b0, 24'h800000, 8'h01, 8, 8'h42, 8'h42, 1'b0, 9};
        tie_rd[0] = 8'h11;
        tie_rd[1] = 8'h22;
        tie_rd[2] = 8'h33;
        tie_rd[3] = 8'h44;

        bus.M_WE = 1'b0;
        bus.M_ADDR = '0;
        bus.M_WDATA = '0;
        bus.D_ADDR = '0;
        bus.FL_RDATA = '0;
        do_reset();
        check_all_zero("reset");

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
        end

        // Completion pulse while idle must be ignored.
        bus.FL_RDATA = 8'h99;
        bus.FL_STATUS = 1'b1;
        @(negedge clk);
        bus.FL_STATUS = 1'b0;
        count_events(4, ev);
        check("idle_status_events", ev, 0);
        check("idle_status_mrdata", 32'(bus.M_RDATA), 32'h42);
        check("idle_status_drdata", 32'(bus.D_RDATA), 32'h81);

        // Reset two cycles into an operation abandons it.
        push_fl(1'b0, 24'h000300, 8'h5E);
        bus.M_WE = 1'b0;
        bus.M_ADDR = 24'h000300;
        bus.M_WDATA = 8'h5E;
        bus.M_REQ = 1'b1;
        wait_start(n);
        check("rst_op_start_lat", n, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.M_REQ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_rst");
        bus.FL_RDATA = 8'hDD;
        bus.FL_STATUS = 1'b1;
        @(negedge clk);
        bus.FL_STATUS = 1'b0;
        count_events(6, ev);
        check("late_status_events", ev, 0);
        check("late_status_rdata", 32'({bus.M_RDATA, bus.D_RDATA}), 32'd0);
        v = '{1'b1, 1'b0, 24'h000400, 8'h00, 2, 8'h6B, 8'h6B, 1'b0, 3};
        run_op(v);

        // Both request together and stay up: manager first after reset, then alternate.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                push_fl(1'b0, 24'h000A00, 8'h12);
                push_done(1'b1, tie_rd[k], 1'b0);
            end else begin
                push_fl(1'b0, 24'h000B00, 8'h00);
                push_done(1'b0, tie_rd[k], 1'b0);
            end
        end
        bus.M_WE = 1'b0;
        bus.M_ADDR = 24'h000A00;
        bus.M_WDATA = 8'h12;
        bus.D_ADDR = 24'h000B00;
        bus.M_REQ = 1'b1;
        bus.D_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            check("tie_start_lat", n, (k == 0) ? 1 : 2);
            bus.FL_RDATA = tie_rd[k];
            @(negedge clk);
            bus.FL_STATUS = 1'b1;
            @(negedge clk);
            bus.FL_STATUS = 1'b0;
            check("tie_done", 32'(bus.M_DONE | bus.D_DONE), 32'd1);
            if (k == 3) begin
                bus.M_REQ = 1'b0;
                bus.D_REQ = 1'b0;
            end
        end
        count_events(4, ev);
        check("tie_drained_events", ev, 0);

        check("fl_q_empty", fl_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
